// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the fetch-control logic and the PC sequencer.
// The master drives the redirect requests; the slave returns the fetch PC state.
interface pc_sequencer_if #(
    parameter int unsigned B = 32
);
    logic         stall;
    logic         branch_taken;
    logic [B-1:0] pc_branch;
    logic         jump_reg;
    logic [B-1:0] pc_jr;
    logic         jump;
    logic [B-1:0] pc_jump;
    logic         exc_req;
    logic [B-1:0] exc_pc;
    logic         eret;
    logic [B-1:0] pc_out;
    logic [B-1:0] pc_incrementado;
    logic [B-1:0] epc;
    logic         redirect_pending;
    logic         misalign;

    modport master (
        output stall, branch_taken, pc_branch, jump_reg, pc_jr, jump, pc_jump,
               exc_req, exc_pc, eret,
        input  pc_out, pc_incrementado, epc, redirect_pending, misalign
    );

    modport slave (
        input  stall, branch_taken, pc_branch, jump_reg, pc_jr, jump, pc_jump,
               exc_req, exc_pc, eret,
        output pc_out, pc_incrementado, epc, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection for the IF stage: exception, ERET, held redirect, branch, JR, J, sequential.
// A redirect that arrives during a stall is captured once and applied when the stall releases.
module pc_sequencer #(
    parameter int unsigned   B            = 32,
    parameter int unsigned   INC          = 4,
    parameter logic [B-1:0]  RESET_VECTOR = '0,
    parameter logic [B-1:0]  EXC_VECTOR   = B'(32'h80),
    parameter int unsigned   ALIGN_BITS   = 2
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.slave  bus
);

    localparam logic [B-1:0] LOW_MASK = (B'(1) << ALIGN_BITS) - B'(1);

    typedef enum logic {StRun, StHold} state_t;

    state_t       state_q;
    logic [B-1:0] pc_q;
    logic [B-1:0] epc_q;
    logic [B-1:0] pend_pc_q;
    logic         pend_mis_q;
    logic         misalign_q;

    logic         redir_vld;
    logic [B-1:0] redir_raw;
    logic [B-1:0] pc_inc;

    // Highest-priority live redirect among the stall-obeying sources below eret.
    always_comb begin
        redir_vld = 1'b1;
        redir_raw = '0;
        if (bus.branch_taken) begin
            redir_raw = bus.pc_branch;
        end else if (bus.jump_reg) begin
            redir_raw = bus.pc_jr;
        end else if (bus.jump) begin
            redir_raw = bus.pc_jump;
        end else begin
            redir_vld = 1'b0;
        end
    end

    assign pc_inc = pc_q + B'(INC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            pend_pc_q  <= '0;
            pend_mis_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (bus.exc_req) begin
                pc_q    <= EXC_VECTOR;
                epc_q   <= bus.exc_pc;
                state_q <= StRun;
            end else if (!bus.stall) begin
                state_q <= StRun;
                if (bus.eret) begin
                    pc_q       <= epc_q & ~LOW_MASK;
                    misalign_q <= |(epc_q & LOW_MASK);
                end else if (state_q == StHold) begin
                    // The older held target wins over anything live this cycle.
                    pc_q       <= pend_pc_q;
                    misalign_q <= pend_mis_q;
                end else if (redir_vld) begin
                    pc_q       <= redir_raw & ~LOW_MASK;
                    misalign_q <= |(redir_raw & LOW_MASK);
                end else begin
                    pc_q <= pc_inc;
                end
            end else if (state_q == StRun && redir_vld) begin
                pend_pc_q  <= redir_raw & ~LOW_MASK;
                pend_mis_q <= |(redir_raw & LOW_MASK);
                state_q    <= StHold;
            end
        end
    end

    assign bus.pc_out           = pc_q;
    assign bus.pc_incrementado  = pc_inc;
    assign bus.epc              = epc_q;
    assign bus.redirect_pending = (state_q == StHold);
    assign bus.misalign         = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a queue-based reference model of the PC rules.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic reset8;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.B(32)) bus32 ();
    pc_sequencer_if #(.B(8))  bus8 ();

    pc_sequencer #(.B(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    pc_sequencer #(.B(8))  dut8  (.clk(clk), .reset(reset8), .bus(bus8));

    // Reference model: at most one held raw target in a queue, alignment applied on load.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_mis;
    logic [31:0] pq[$];

    always @(posedge clk) begin
        logic [31:0] tgt;
        logic [31:0] ld;
        bit          have;
        bit          load;
        if (reset) begin
            m_pc = 32'h0;
            m_epc = 32'h0;
            m_mis = 1'b0;
            pq.delete();
        end else begin
            have = 1'b1;
            load = 1'b0;
            ld   = 32'h0;
            tgt  = 32'h0;
            if (bus32.branch_taken)  tgt = bus32.pc_branch;
            else if (bus32.jump_reg) tgt = bus32.pc_jr;
            else if (bus32.jump)     tgt = bus32.pc_jump;
            else                     have = 1'b0;
            m_mis = 1'b0;
            if (bus32.exc_req) begin
                m_pc  = 32'h80;
                m_epc = bus32.exc_pc;
                pq.delete();
            end else if (!bus32.stall) begin
                if (bus32.eret) begin
                    load = 1'b1;
                    ld   = m_epc;
                    pq.delete();
                end else if (pq.size() != 0) begin
                    load = 1'b1;
                    ld   = pq.pop_front();
                end else if (have) begin
                    load = 1'b1;
                    ld   = tgt;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
                if (load) begin
                    m_pc  = {ld[31:2], 2'b00};
                    m_mis = (ld % 4) != 0;
                end
            end else if (pq.size() == 0 && have) begin
                pq.push_back(tgt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_pc_out", bus32.pc_out, m_pc);
            chk("m_pc_inc", bus32.pc_incrementado, m_pc + 32'd4);
            chk("m_epc", bus32.epc, m_epc);
            chk("m_pending", {31'b0, bus32.redirect_pending}, {31'b0, pq.size() != 0});
            chk("m_misalign", {31'b0, bus32.misalign}, {31'b0, m_mis});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr32();
        bus32.stall = 0; bus32.branch_taken = 0; bus32.jump_reg = 0; bus32.jump = 0;
        bus32.exc_req = 0; bus32.eret = 0;
        bus32.pc_branch = '0; bus32.pc_jr = '0; bus32.pc_jump = '0; bus32.exc_pc = '0;
    endtask

    task automatic clr8();
        bus8.stall = 0; bus8.branch_taken = 0; bus8.jump_reg = 0; bus8.jump = 0;
        bus8.exc_req = 0; bus8.eret = 0;
        bus8.pc_branch = '0; bus8.pc_jr = '0; bus8.pc_jump = '0; bus8.exc_pc = '0;
    endtask

    initial begin
        clr32();
        clr8();
        reset  = 1;
        reset8 = 1;
        tick();
        tick();
        chk_en = 1'b1;
        // 1: reset state and free run
        chk("rst_pc", bus32.pc_out, 32'h0);
        chk("rst_epc", bus32.epc, 32'h0);
        chk("rst_pend", {31'b0, bus32.redirect_pending}, 32'h0);
        chk("rst_mis", {31'b0, bus32.misalign}, 32'h0);
        reset = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_pc", bus32.pc_out, 32'(4 * i));
            chk("seq_inc", bus32.pc_incrementado, 32'(4 * i + 4));
        end
        // 2: branch beats jump
        bus32.branch_taken = 1; bus32.pc_branch = 32'h40;
        bus32.jump = 1; bus32.pc_jump = 32'h100;
        tick();
        clr32();
        chk("prio_pc", bus32.pc_out, 32'h40);
        // 3: redirect held across stall
        bus32.stall = 1; bus32.jump = 1; bus32.pc_jump = 32'h200;
        tick();
        bus32.jump = 0;
        chk("hold_pc", bus32.pc_out, 32'h40);
        chk("hold_pend", {31'b0, bus32.redirect_pending}, 32'h1);
        tick();
        tick();
        chk("hold_pc3", bus32.pc_out, 32'h40);
        bus32.stall = 0;
        tick();
        chk("rel_pc", bus32.pc_out, 32'h200);
        chk("rel_pend", {31'b0, bus32.redirect_pending}, 32'h0);
        // 4: exception while holding, then eret
        bus32.stall = 1; bus32.jump = 1; bus32.pc_jump = 32'h200;
        tick();
        bus32.jump = 0;
        chk("hold2_pend", {31'b0, bus32.redirect_pending}, 32'h1);
        bus32.exc_req = 1; bus32.exc_pc = 32'h1C;
        tick();
        clr32();
        chk("exc_pc", bus32.pc_out, 32'h80);
        chk("exc_epc", bus32.epc, 32'h1C);
        chk("exc_pend", {31'b0, bus32.redirect_pending}, 32'h0);
        bus32.eret = 1;
        tick();
        clr32();
        chk("eret_pc", bus32.pc_out, 32'h1C);
        // 5: misaligned JR target
        bus32.jump_reg = 1; bus32.pc_jr = 32'h103;
        tick();
        clr32();
        chk("mis_pc", bus32.pc_out, 32'h100);
        chk("mis_on", {31'b0, bus32.misalign}, 32'h1);
        tick();
        chk("mis_off", {31'b0, bus32.misalign}, 32'h0);
        // 6: 8-bit wrap and reset while holding
        reset8 = 0;
        bus8.jump = 1; bus8.pc_jump = 8'hFC;
        tick();
        clr8();
        chk("w8_pc", {24'b0, bus8.pc_out}, 32'hFC);
        chk("w8_inc", {24'b0, bus8.pc_incrementado}, 32'h00);
        tick();
        chk("w8_wrap", {24'b0, bus8.pc_out}, 32'h00);
        bus8.stall = 1; bus8.jump = 1; bus8.pc_jump = 8'h10;
        tick();
        chk("w8_pend", {31'b0, bus8.redirect_pending}, 32'h1);
        reset8 = 1;
        tick();
        clr8();
        chk("w8_rst_pc", {24'b0, bus8.pc_out}, 32'h00);
        chk("w8_rst_pend", {31'b0, bus8.redirect_pending}, 32'h0);
        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset              = ($urandom_range(0, 99) == 0);
            bus32.stall        = ($urandom_range(0, 9) < 3);
            bus32.branch_taken = ($urandom_range(0, 99) < 15);
            bus32.jump_reg     = ($urandom_range(0, 99) < 10);
            bus32.jump         = ($urandom_range(0, 99) < 10);
            bus32.exc_req      = ($urandom_range(0, 99) < 3);
            bus32.eret         = ($urandom_range(0, 99) < 5);
            bus32.pc_branch    = $urandom;
            bus32.pc_jr        = $urandom;
            bus32.pc_jump      = $urandom & 32'hFFFF_FFFC;
            bus32.exc_pc       = $urandom;
            tick();
        end
        reset = 0;
        clr32();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
